// File: rtl/lcd_cmd_queue.sv
// Command FIFO and issuer placed in front of LCD_CTRL: buffers host commands and
// strobes them out one per busy window, halting after the Write command or on done.
module lcd_cmd_queue #(
    parameter int unsigned         DEPTH       = 16,
    parameter int unsigned         CMD_W       = 4,
    parameter logic [CMD_W-1:0]    WRITE_CMD   = '0,
    parameter int unsigned         ACK_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CMD_W-1:0]           host_cmd,
    input  logic                       host_valid,
    output logic                       host_ready,
    output logic [CMD_W-1:0]           cmd,
    output logic                       cmd_valid,
    input  logic                       busy,
    input  logic                       done,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [7:0]                 issued_cnt,
    output logic                       halted,
    output logic                       drop_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        HALT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    state_t           after_cmd;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_cnt;
    logic [CW-1:0]    rd_cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [TW-1:0]    tmo;
    logic [TW-1:0]    tmo_nxt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Counters carry one extra bit so full and empty are distinguishable.
    assign wr_ptr     = wr_cnt[AW-1:0];
    assign rd_ptr     = rd_cnt[AW-1:0];
    assign q_count    = wr_cnt - rd_cnt;
    assign full       = (q_count == CW'(DEPTH));
    assign empty      = (q_count == '0);
    assign halted     = (state == HALT);
    assign host_ready = !full && !halted;
    assign push       = host_valid && host_ready;
    assign pop        = (state_nxt == ISSUE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    // A command that has run its course either ends the sequence or frees the issuer.
    always_comb begin
        after_cmd = (cmd == WRITE_CMD) ? HALT : IDLE;
    end

    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo;
        case (state)
            IDLE: begin
                if (!empty && !busy) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACK;
                tmo_nxt   = '0;
            end
            WAIT_ACK: begin
                if (busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
                    state_nxt = after_cmd;
                end else begin
                    tmo_nxt = tmo + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_nxt = after_cmd;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (done) begin
            state_nxt = HALT;
        end
    end

    // cmd_valid is high exactly while in ISSUE, and cmd keeps the last issued value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tmo        <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            issued_cnt <= 8'd0;
            drop_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo       <= tmo_nxt;
            cmd_valid <= pop;
            if (push) begin
                wr_cnt <= wr_cnt + CW'(1);
            end
            if (pop) begin
                rd_cnt <= rd_cnt + CW'(1);
                cmd    <= mem[rd_ptr];
                if (issued_cnt != 8'hFF) begin
                    issued_cnt <= issued_cnt + 8'd1;
                end
            end
            if (host_valid && halted) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Scoreboard bench for lcd_cmd_queue: accepted host commands form the expected
// issue stream, truncated after the Write opcode; a negedge monitor checks the DUT.
module tb_lcd_cmd_queue;

    localparam int         DEPTH       = 16;
    localparam int         CMD_W       = 4;
    localparam logic [3:0] WRITE_CMD   = 4'h0;
    localparam int         ACK_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic [4:0] q_count;
    logic [7:0] issued_cnt;
    logic       halted;
    logic       drop_err;

    lcd_cmd_queue #(
        .DEPTH(DEPTH), .CMD_W(CMD_W), .WRITE_CMD(WRITE_CMD), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
        .host_ready(host_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .done(done), .q_count(q_count), .issued_cnt(issued_cnt), .halted(halted),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [3:0] exp_q[$];
    int         issue_cycles[$];
    int         push_total   = 0;
    int         issue_total  = 0;
    bit         write_issued = 0;
    bit         done_flag    = 0;
    bit         prev_cv      = 0;
    bit         prev_busy    = 0;
    logic [3:0] exp_cmd;

    // busy_mode: 0 = level busy_level, 1 = short random busy after each strobe,
    // 2 = never busy, 3 = very long busy after each strobe
    int         busy_mode  = 0;
    bit         busy_level = 0;
    int         busy_left  = 0;
    bit         busy_nb;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] c);
        bit ok = 0;
        host_cmd   = c;
        host_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (host_ready) begin
                ok = 1;
                break;
            end
        end
        checkOutput("push_accept", ok, 1);
        @(posedge clk);
        #1;
        host_valid = 1'b0;
    endtask

    task automatic doReset();
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = 4'h0;
        done       = 1'b0;
        done_flag  = 0;
        waitCycles(3);
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            waitCycles(1);
            if (push_total == issue_total) begin
                ok = 1;
                break;
            end
        end
        checkOutput(name, ok, 1);
        waitCycles(14);
    endtask

    // Bench-side LCD_CTRL stand-in for the busy flag.
    initial begin
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) busy_left = 0;
            case (busy_mode)
                0: busy_nb = busy_level;
                1, 3: begin
                    if (cmd_valid && !reset) busy_left = (busy_mode == 1) ? $urandom_range(1, 5) : 100;
                    else if (busy_left > 0) busy_left--;
                    busy_nb = (busy_left > 0);
                end
                default: busy_nb = 1'b0;
            endcase
            @(posedge clk);
            #1;
            busy = busy_nb;
        end
    end

    // Monitor: pops the expected stream on every strobe and tracks occupancy.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            issue_cycles.delete();
            push_total   = 0;
            issue_total  = 0;
            write_issued = 0;
            prev_cv      = 0;
        end else begin
            if (cmd_valid) begin
                checkOutput("cmd_valid_back_to_back", prev_cv, 0);
                checkOutput("issue_while_busy", prev_busy, 0);
                if (write_issued || exp_q.size() == 0) begin
                    checkOutput("unexpected_issue", cmd_valid, 0);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    issue_total++;
                    checkOutput("cmd_order", cmd, exp_cmd);
                    checkOutput("issued_cnt", issued_cnt, (issue_total > 255) ? 255 : issue_total);
                    if (exp_cmd == WRITE_CMD) write_issued = 1;
                    if (issue_cycles.size() > 0)
                        checkOutput("issue_spacing_ge3", (cyc - issue_cycles[issue_cycles.size()-1]) >= 3, 1);
                    issue_cycles.push_back(cyc);
                end
            end
            checkOutput("q_count", q_count, push_total - issue_total);
            checkOutput("host_ready", host_ready, ((push_total - issue_total) != DEPTH) && !halted);
            if (!write_issued && !done_flag) checkOutput("halted_early", halted, 0);
            if (host_valid && host_ready) begin
                exp_q.push_back(host_cmd);
                push_total++;
            end
            prev_cv = cmd_valid;
        end
        prev_busy = busy;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        reset = 1'b1; host_valid = 1'b0; host_cmd = 4'h0; done = 1'b0;

        // 1: LCD_CTRL busy out of reset; queue keeps accepting and waits.
        $display("[TB] scenario 1: busy at reset exit");
        busy_mode = 0; busy_level = 1;
        doReset();
        @(negedge clk);
        checkOutput("rst_host_ready", host_ready, 1);
        checkOutput("rst_cmd_valid", cmd_valid, 0);
        checkOutput("rst_cmd", cmd, 0);
        checkOutput("rst_q_count", q_count, 0);
        checkOutput("rst_issued_cnt", issued_cnt, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_drop_err", drop_err, 0);
        waitCycles(1);
        applyStimulus(4'd3);
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        waitCycles(62);
        checkOutput("s1_no_issue_while_busy", issued_cnt, 0);
        checkOutput("s1_q_count", q_count, 3);
        busy_mode = 1;
        waitDrain("s1_drain");
        checkOutput("s1_issued", issued_cnt, 3);

        // 2: fill to DEPTH, 17th held off, then drained in order.
        $display("[TB] scenario 2: full queue");
        busy_mode = 0; busy_level = 1;
        doReset();
        waitCycles(2);
        for (int i = 0; i < DEPTH; i++) applyStimulus(4'($urandom_range(1, 15)));
        host_cmd = 4'($urandom_range(1, 15));
        host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("s2_full_count", q_count, DEPTH);
            checkOutput("s2_ready_low", host_ready, 0);
        end
        waitCycles(1);
        busy_mode = 1;
        applyStimulus(host_cmd);
        waitDrain("s2_drain");
        checkOutput("s2_issued", issued_cnt, DEPTH + 1);

        // 3: random traffic with busy windows after each strobe.
        $display("[TB] scenario 3: random traffic");
        busy_mode = 1;
        doReset();
        for (int i = 0; i < 30; i++) begin
            applyStimulus(4'($urandom_range(1, 15)));
            waitCycles($urandom_range(0, 6));
        end
        waitDrain("s3_drain");
        checkOutput("s3_issued", issued_cnt, 30);

        // 4: busy never acknowledges; each issue completes by timeout.
        $display("[TB] scenario 4: ack timeout");
        busy_mode = 0; busy_level = 1;
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(4'($urandom_range(1, 15)));
        busy_mode = 2;
        waitDrain("s4_drain");
        checkOutput("s4_issued", issued_cnt, 3);
        checkOutput("s4_strobes", issue_cycles.size(), 3);
        if (issue_cycles.size() >= 3) begin
            // strobe cycle + ACK_TIMEOUT wait cycles + one IDLE cycle
            checkOutput("s4_gap1", issue_cycles[1] - issue_cycles[0], ACK_TIMEOUT + 2);
            checkOutput("s4_gap2", issue_cycles[2] - issue_cycles[1], ACK_TIMEOUT + 2);
        end

        // 5: Write opcode ends the sequence; later host traffic is flagged.
        $display("[TB] scenario 5: halt after write");
        busy_mode = 0; busy_level = 1;
        doReset();
        applyStimulus(4'd5);
        applyStimulus(WRITE_CMD);
        applyStimulus(4'd7);
        busy_mode = 1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            waitCycles(1);
            if (halted) begin ok = 1; break; end
        end
        checkOutput("s5_halted", ok, 1);
        waitCycles(3);
        @(negedge clk);
        checkOutput("s5_q_count", q_count, 1);
        checkOutput("s5_issued", issued_cnt, 2);
        checkOutput("s5_ready", host_ready, 0);
        checkOutput("s5_drop_clear", drop_err, 0);
        waitCycles(1);
        host_cmd = 4'd9; host_valid = 1'b1;
        waitCycles(1);
        host_valid = 1'b0;
        @(negedge clk);
        checkOutput("s5_drop_set", drop_err, 1);
        waitCycles(4);
        checkOutput("s5_drop_sticky", drop_err, 1);
        checkOutput("s5_still_halted", halted, 1);

        // 6: reset while waiting for busy to fall with entries queued.
        $display("[TB] scenario 6: reset mid-operation");
        busy_mode = 0; busy_level = 1;
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(4'($urandom_range(1, 15)));
        busy_mode = 3;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_valid) begin ok = 1; break; end
        end
        checkOutput("s6_first_issue", ok, 1);
        waitCycles(3);
        @(negedge clk);
        checkOutput("s6_q_before", q_count, 4);
        waitCycles(1);
        reset = 1'b1;
        waitCycles(1);
        @(negedge clk);
        checkOutput("s6_q_after", q_count, 0);
        checkOutput("s6_cv_after", cmd_valid, 0);
        checkOutput("s6_ready_after", host_ready, 1);
        checkOutput("s6_halted_after", halted, 0);
        waitCycles(1);
        reset = 1'b0;
        busy_mode = 0; busy_level = 0;
        waitCycles(3);

        // 7: done forces HALT and blocks any further issue.
        $display("[TB] scenario 7: done from LCD_CTRL");
        busy_mode = 0; busy_level = 1;
        doReset();
        applyStimulus(4'd6);
        applyStimulus(4'd8);
        done_flag = 1;
        done = 1'b1;
        waitCycles(1);
        done = 1'b0;
        @(negedge clk);
        checkOutput("s7_halted", halted, 1);
        checkOutput("s7_ready", host_ready, 0);
        waitCycles(1);
        busy_mode = 2;
        waitCycles(12);
        checkOutput("s7_no_issue", issued_cnt, 0);
        checkOutput("s7_q_kept", q_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
